// File: rtl/riscv_mem_pkg.sv
// Shared RISC-V load/store definitions: funct3 width codes, LSU state encoding,
// default data-memory depth and a funct3 legality helper.
package riscv_mem_pkg;

  localparam int MEM_WORDS_DEFAULT = 512;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDW,
    WR,
    FLT
  } lsu_state_t;

  // Stores only have signed-width codes; loads add the unsigned byte/half forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/half extraction with sign/zero extension,
// and byte/half merge of store data into a read word for read-modify-write.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [3:0][7:0] lane;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;

  assign lane     = rdata;
  assign sel_byte = lane[byte_off];
  assign sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = rdata;
    endcase
  end

  // Each byte lane independently decides whether store data replaces it.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      localparam bit HI = (gi >= 2);
      logic hit_b;
      logic hit_h;
      assign hit_b = (funct3[1:0] == 2'b00) && (byte_off == 2'(gi));
      assign hit_h = (funct3[1:0] == 2'b01) && (byte_off[1] == HI);
      assign merge_data[8*gi +: 8] = hit_b ? wdata[7:0] :
                                     hit_h ? wdata[8*(gi%2) +: 8] : lane[gi];
    end
  endgenerate

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store sequencer for a word-wide registered-read memory.
// Optional LSU_MISALIGN_TRAP_EN: fault misaligned accesses instead of aligning them.
module lsu_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state_reg, state_next;
  logic        we_reg;
  logic [2:0]  f3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        rsp_valid_reg;
  logic        rsp_fault_reg;
  logic [31:0] rsp_rdata_reg;

  logic        accept;
  logic        misalign;
  logic        out_of_range;
  logic        req_fault;
  logic [31:0] aligned_addr;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign req_ready = !RST && (state_reg == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    aligned_addr = req_addr;
    case (req_funct3[1:0])
      2'b01:   aligned_addr[0]   = 1'b0;
      2'b10:   aligned_addr[1:0] = 2'b00;
      default: aligned_addr      = req_addr;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign out_of_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
  assign req_fault    = !f3_legal(req_we, req_funct3) || out_of_range || misalign;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) begin
        if (req_fault)
          state_next = FLT;
        else if (req_we && (req_funct3 == F3_W))
          state_next = WR;
        else
          state_next = RD;
      end
      RD:      state_next = RDW;
      RDW:     state_next = IDLE;
      WR:      state_next = IDLE;
      FLT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset masks the write strobe immediately so an interrupted RMW cannot land.
  assign mem_we    = !RST && ((state_reg == WR) || ((state_reg == RDW) && we_reg));
  assign mem_addr  = RST ? 32'h0 : {2'b00, addr_reg[31:2]};
  assign mem_wdata = (state_reg == RDW) ? merge_data : wdata_reg;

  lsu_align u_align (
    .funct3     (f3_reg),
    .byte_off   (addr_reg[1:0]),
    .rdata      (mem_rdata),
    .wdata      (wdata_reg[15:0]),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      f3_reg        <= 3'b000;
      addr_reg      <= 32'h0;
      wdata_reg     <= 32'h0;
      rsp_valid_reg <= 1'b0;
      rsp_fault_reg <= 1'b0;
      rsp_rdata_reg <= 32'h0;
    end else begin
      state_reg     <= state_next;
      rsp_valid_reg <= 1'b0;
      if (accept) begin
        we_reg    <= req_we;
        f3_reg    <= req_funct3;
        addr_reg  <= req_fault ? 32'h0 : aligned_addr;
        wdata_reg <= req_wdata;
      end
      case (state_reg)
        RDW: begin
          rsp_valid_reg <= 1'b1;
          rsp_fault_reg <= 1'b0;
          rsp_rdata_reg <= we_reg ? 32'h0 : load_data;
        end
        WR: begin
          rsp_valid_reg <= 1'b1;
          rsp_fault_reg <= 1'b0;
          rsp_rdata_reg <= 32'h0;
        end
        FLT: begin
          rsp_valid_reg <= 1'b1;
          rsp_fault_reg <= 1'b1;
          rsp_rdata_reg <= 32'h0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_fault = rsp_fault_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: registered-read memory model plus a
// byte-addressed reference model; honours LSU_MISALIGN_TRAP_EN like the DUT.
module tb_lsu_ctrl;

  localparam int MW = 512;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  lsu_ctrl #(.MEM_WORDS(MW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  // Data memory: contents loaded at the first reset, registered read port.
  logic [31:0] mem [MW];
  int unsigned wr_count   = 0;
  bit          mem_loaded = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      if (!mem_loaded) begin
        for (int i = 0; i < MW; i++) mem[i] <= 32'(i);
        mem_loaded <= 1'b1;
      end
      mem_rdata <= 32'h0;
    end else if (mem_we) begin
      if (mem_addr < 32'(MW)) mem[mem_addr[8:0]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end else begin
      mem_rdata <= (mem_addr < 32'(MW)) ? mem[mem_addr[8:0]] : 32'h0;
    end
  end

  // Reference model: byte-addressed little-endian image of the memory.
  logic [7:0] ref_bytes [MW*4];

  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output bit fault,
                                output logic [31:0] rd, output int lat);
    bit legal;
    int nb;
    int a;
    logic [31:0] v;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nb    = 1 << f3[1:0];
    fault = !legal || ((addr >> 2) >= 32'(MW));
`ifdef LSU_MISALIGN_TRAP_EN
    if (legal && (addr % nb) != 0) fault = 1'b1;
`endif
    rd = 32'h0;
    if (fault) begin
      lat = 1;
      return;
    end
    a = int'(addr) - int'(addr % nb);
    if (we) begin
      for (int k = 0; k < nb; k++) ref_bytes[a+k] = wd[8*k +: 8];
      lat = (nb == 4) ? 1 : 2;
    end else begin
      v = 32'h0;
      for (int k = 0; k < nb; k++) v = v | (32'(ref_bytes[a+k]) << (8*k));
      if (nb < 4 && !f3[2] && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rd  = v;
      lat = 2;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] last_rdata;
  logic        last_fault;
  logic [31:0] held_rdata = 32'h0;

  // One request: issued at a negedge, response awaited within a bounded window.
  task automatic do_req(input string tag, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    bit          efault;
    logic [31:0] erd;
    int          elat;
    int          n;
    bit          got;
    int unsigned wc0;
    model(we, f3, addr, wd, efault, erd, elat);
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    wc0        = wr_count;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    chk({tag, ".pulse_low"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".hold"}, rsp_rdata, held_rdata);
    n   = 0;
    got = 1'b0;
    while (!got && n < 6) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      got = rsp_valid;
    end
    chk({tag, ".latency"}, 32'(n), 32'(elat));
    chk({tag, ".fault"}, 32'(rsp_fault), 32'(efault));
    chk({tag, ".rdata"}, rsp_rdata, erd);
    chk({tag, ".ready_in_rsp"}, 32'(req_ready), 32'd1);
    chk({tag, ".writes"}, 32'(wr_count - wc0), (we && !efault) ? 32'd1 : 32'd0);
    $display("txn %-10s we=%0d f3=%0d addr=%h wdata=%h -> lat=%0d fault=%0d rdata=%h",
             tag, we, f3, addr, wd, n, rsp_fault, rsp_rdata);
    last_rdata = rsp_rdata;
    last_fault = rsp_fault;
    held_rdata = rsp_rdata;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned wc0;
    logic [31:0] ra;
    for (int i = 0; i < MW; i++)
      for (int k = 0; k < 4; k++) ref_bytes[4*i+k] = 8'((i >> (8*k)) & 255);

    RST        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.rsp_fault", 32'(rsp_fault), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst.ready", 32'(req_ready), 32'd1);

    do_req("lw14", 1'b0, 3'b010, 32'h14, 32'h0);
    chk("lw14.value", last_rdata, 32'h0000_0005);
    do_req("sb15", 1'b1, 3'b000, 32'h15, 32'hAB);
    do_req("lb15", 1'b0, 3'b000, 32'h15, 32'h0);
    chk("lb15.value", last_rdata, 32'hFFFF_FFAB);
    do_req("lbu15", 1'b0, 3'b100, 32'h15, 32'h0);
    chk("lbu15.value", last_rdata, 32'h0000_00AB);
    do_req("lw14b", 1'b0, 3'b010, 32'h14, 32'h0);
    chk("lw14b.value", last_rdata, 32'h0000_AB05);
    do_req("sh22", 1'b1, 3'b001, 32'h22, 32'h8001);
    do_req("lh22", 1'b0, 3'b001, 32'h22, 32'h0);
    chk("lh22.value", last_rdata, 32'hFFFF_8001);
    chk("word8", mem[8], 32'h8001_0008);
    do_req("lw06", 1'b0, 3'b010, 32'h06, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw06.fault", 32'(last_fault), 32'd1);
`else
    chk("lw06.value", last_rdata, 32'h0000_0001);
`endif
    do_req("lw800", 1'b0, 3'b010, 32'h800, 32'h0);
    chk("lw800.fault", 32'(last_fault), 32'd1);
    chk("lw800.rdata", last_rdata, 32'h0);
    do_req("f3_011", 1'b0, 3'b011, 32'h10, 32'h0);
    chk("f3_011.fault", 32'(last_fault), 32'd1);

    // Reset lands while an SB is in RD: no response, no write.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h31;
    req_wdata  = 32'h5A;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    RST       = 1'b1;
    wc0       = wr_count;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    held_rdata = 32'h0;
    for (int c = 0; c < 4; c++) begin
      chk("rstmid.no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge CLK);
    end
    chk("rstmid.no_write", 32'(wr_count - wc0), 32'd0);
    chk("rstmid.ready", 32'(req_ready), 32'd1);
    chk("rstmid.word12", mem[12], 32'd12);
    $display("txn rstmid     SB 0x31 aborted by RST, writes=%0d", wr_count - wc0);
    do_req("lw30", 1'b0, 3'b010, 32'h30, 32'h0);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 9) == 0)
        ra = {$urandom_range(MW, MW + 40), 2'(  $urandom_range(0, 3))};
      else
        ra = {32'($urandom_range(0, 31)) << 2} | 32'($urandom_range(0, 3));
      do_req($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             ra, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
